// File: rtl/ka_seq_mult.sv
// Sequential Karatsuba carry-less multiplier over GF(2)[x] with optional
// reduction modulo x^W + POLY, built around one shared half-width multiplier.
module ka_seq_mult #(
  parameter int             W    = 193,
  parameter logic [W-1:0]   POLY = 193'h8001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-2:0]   y,
  output logic [2:0]       dbg_state
);

  localparam int H  = (W + 1) / 2;
  localparam int PW = 2 * H - 1;
  localparam int YW = 2 * W - 1;

  // Handshake: a beat transfers on any rising edge where valid && ready on
  // the same side; out_valid/y hold steady until out_ready is seen high.
  typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, RED, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_q, b_q;
  logic            mode_q;
  logic [PW-1:0]   p0, p1;
  logic [YW-1:0]   y_reg;

  logic [H-1:0]    a_lo, a_hi, b_lo, b_hi;
  logic [H-1:0]    op_x, op_y;
  logic [PW-1:0]   prod, mid;
  logic [YW-1:0]   red;
  logic            accept;

  function automatic logic [PW-1:0] clmul_h(input logic [H-1:0] x,
                                            input logic [H-1:0] z);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++)
      if (x[i]) r ^= PW'(z) << i;
    return r;
  endfunction

  // For odd W the high half is one bit narrower, so its zero-extended top
  // bit keeps p1 clear of any coefficient above x^(2W-2).
  assign a_lo = a_q[H-1:0];
  assign b_lo = b_q[H-1:0];
  assign a_hi = H'(a_q[W-1:H]);
  assign b_hi = H'(b_q[W-1:H]);

  always_comb begin
    op_x = a_lo;
    op_y = b_lo;
    case (state)
      MUL1: begin
        op_x = a_hi;
        op_y = b_hi;
      end
      MUL2: begin
        op_x = a_lo ^ a_hi;
        op_y = b_lo ^ b_hi;
      end
      default: ;
    endcase
  end

  assign prod = clmul_h(op_x, op_y);
  assign mid  = prod ^ p0 ^ p1;

  // Top-down fold: each set bit at x^i (i >= W) is cancelled by x^(i-W)
  // times the full modulus, which only touches lower coefficients.
  always_comb begin
    red = y_reg;
    for (int i = YW - 1; i >= W; i--)
      if (red[i]) red ^= YW'({1'b1, POLY}) << (i - W);
  end

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign y         = y_reg;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      p0     <= '0;
      p1     <= '0;
      y_reg  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            state  <= MUL0;
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        MUL0: begin
          p0    <= prod;
          state <= MUL1;
        end
        MUL1: begin
          p1    <= prod;
          state <= MUL2;
        end
        MUL2: begin
          y_reg <= YW'(p0) ^ (YW'(mid) << H) ^ (YW'(p1) << (2 * H));
          state <= mode_q ? RED : DONE;
        end
        RED: begin
          y_reg <= red;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ka_seq_mult.md
KA_SEQ_MULT -- requirements
Module: ka_seq_mult

Interface
REQ-001 Parameter W, default 193: operand width in bits; W >= 2, odd or even.
REQ-002 Parameter POLY, default 193'h8001: low W coefficients of the reduction polynomial; the x^W term is implied (default x^193+x^15+1).
REQ-003 Derived value H = (W+1)/2 (integer division); this is the low-half width, and the high half is W-H bits zero-extended to H.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port in_valid, input, 1 bit: the operand/mode beat is valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 Port a, input, W bits: GF(2)[x] operand A, bit i = coefficient of x^i.
REQ-009 Port b, input, W bits: GF(2)[x] operand B.
REQ-010 Port mode, input, 1 bit: 0 = full carry-less product; 1 = product reduced mod (x^W + POLY).
REQ-011 Port out_valid, output, 1 bit: the result on y is valid.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 Port y, output, 2W-1 bits: the result; in mode 1, bits [2W-2:W] SHALL be 0.

Function
REQ-014 All arithmetic SHALL be carry-less (AND for multiply, XOR for add); there are no integer carries anywhere.
REQ-015 The block SHALL contain exactly one shared H x H carry-less multiplier core (product 2H-1 bits), time-multiplexed over three cycles.
REQ-016 The FSM SHALL have states IDLE, MUL0, MUL1, MUL2, RED and DONE, and only these.
REQ-017 A transfer SHALL occur on any edge where in_valid && in_ready; that edge latches a, b and mode and moves the FSM to MUL0.
REQ-018 mode SHALL be sampled only on the accept edge; later changes to mode SHALL have no effect on the job in flight.
REQ-019 In MUL0, the edge SHALL register p0 = a_lo*b_lo, where a_lo = a[H-1:0]; next state is MUL1.
REQ-020 In MUL1, the edge SHALL register p1 = a_hi*b_hi; next state is MUL2.
REQ-021 In MUL2, the edge SHALL compute pm = (a_lo^a_hi)*(b_lo^b_hi) and load y_reg = p0 ^ ((pm^p0^p1) << H) ^ (p1 << 2H), truncated to 2W-1 bits.
REQ-022 From MUL2, next state SHALL be DONE if mode = 0 and RED if mode = 1.
REQ-023 In RED, the edge SHALL load y_reg with y_reg reduced mod (x^W + POLY) in a single cycle (combinational fold), then go to DONE.
REQ-024 Latency from the accept edge to out_valid = 1 SHALL be 3 edges in mode 0 and 4 edges in mode 1.
REQ-025 out_valid SHALL be high only in DONE, and y SHALL be driven from y_reg.
REQ-026 While out_valid && !out_ready, y and out_valid SHALL stay stable.
REQ-027 in_ready SHALL equal (state == IDLE) || (state == DONE && out_ready).
REQ-028 In DONE with out_ready = 1: if in_valid = 1, the FSM SHALL accept the new beat and go to MUL0 on the same edge; otherwise it SHALL go to IDLE.
REQ-029 in_valid SHALL be ignored in MUL0, MUL1, MUL2 and RED.
REQ-030 Sustained throughput SHALL be one result per 4 cycles (mode 0) or 5 cycles (mode 1).
REQ-031 For odd W, the top bit of the zero-extended high half SHALL never contribute a nonzero coefficient above x^(2W-2).

Reset
REQ-032 While rst is high, state SHALL be IDLE, and in_ready = 1, out_valid = 0, y = 0.
REQ-033 Reset asserted in any state, including mid-job, SHALL abort the job with no output produced; the first cycle after deassertion SHALL show in_ready = 1.
REQ-034 Internal registers p0, p1, the latched operands and mode SHALL reset to 0.

Verification
REQ-035 W=193, mode 0, a=1, b=1 -> out_valid rises 3 edges after accept, with y=1.
REQ-036 W=193, mode 0, a=b=2^192 -> y = 2^384 (only bit 384 set); mode 1, a=2^192, b=2 -> after 4 edges y = 0x8001.
REQ-037 Backpressure: out_ready held low 5 cycles in DONE -> y and out_valid are unchanged every cycle; out_ready=1 with in_valid=1 -> next job is accepted on that edge, with no bubble.
REQ-038 Reset mid-job: rst pulsed during MUL1 -> out_valid=0, y=0, and no result ever appears for that job; a new job then completes normally.
REQ-039 W=5, POLY=5'h05: exhaustive a, b in 0..31, both modes, random in_valid/out_ready -> every y matches the carry-less reference model, delivered in order.
REQ-040 Mode change after accept: mode=0 at accept, driven to 1 during MUL0..MUL2 -> latency stays 3 and y is the unreduced product.
